// File: rtl/clz_norm_pipe.sv
// Pipelined leading-zero counter and normaliser (binary-search shifter, valid/ready, sideband tag).
// Define CLZ_ZERO_FLAG_EN to add the registered io_out_zero output.
module clz_norm_pipe #(
    parameter int W            = 128,
    parameter int STAGE_LEVELS = 2,
    parameter int TAG_W        = 8,
    localparam int LOG2W       = $clog2(W),
    localparam int CNT_W       = LOG2W + 1,
    localparam int L           = (LOG2W + STAGE_LEVELS - 1) / STAGE_LEVELS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [W-1:0]     io_in_bits,
    input  logic [TAG_W-1:0] io_in_tag,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [CNT_W-1:0] io_out_count,
    output logic [W-1:0]     io_out_norm,
    output logic [TAG_W-1:0] io_out_tag
`ifdef CLZ_ZERO_FLAG_EN
    ,
    output logic             io_out_zero
`endif
);

    logic [L-1:0]     valid_q;
    logic [W-1:0]     word_q [L];
    logic [CNT_W-1:0] cnt_q  [L];
    logic [TAG_W-1:0] tag_q  [L];

    logic [W-1:0]     word_d [L];
    logic [CNT_W-1:0] cnt_d  [L];
    logic [TAG_W-1:0] tag_d  [L];

    logic [L:0]       src_valid;
    logic [W-1:0]     src_word [L+1];
    logic [CNT_W-1:0] src_cnt  [L+1];
    logic [TAG_W-1:0] src_tag  [L+1];

    logic [L-1:0]     load;

    // Entry s of the src_* arrays is what stage s loads from; entry 0 is the input port.
    assign src_valid = {valid_q, io_in_valid};

    always_comb begin : src_sel
        src_word[0] = io_in_bits;
        src_cnt[0]  = '0;
        src_tag[0]  = io_in_tag;
        for (int s = 0; s < L; s++) begin
            src_word[s+1] = word_q[s];
            src_cnt[s+1]  = cnt_q[s];
            src_tag[s+1]  = tag_q[s];
        end
    end

    // A stage loads when it is empty or everything downstream of it moves this cycle.
    always_comb begin : ready_chain
        logic run;
        load = '0;
        run  = io_out_ready;
        for (int s = L - 1; s >= 0; s--) begin
            run     = run || !valid_q[s];
            load[s] = run;
        end
    end

    always_comb begin : search
        logic [W-1:0]     w;
        logic [CNT_W-1:0] c;
        int               lvl;
        for (int s = 0; s < L; s++) begin
            // NOTE: w and c are blocking temporaries; each level must see the previous level's shift.
            w = src_word[s];
            c = src_cnt[s];
            for (int i = 0; i < STAGE_LEVELS && (s * STAGE_LEVELS + i) < LOG2W; i++) begin
                lvl = LOG2W - 1 - (s * STAGE_LEVELS + i);
                if ((w >> (W - (1 << lvl))) == '0) begin
                    w = w << (1 << lvl);
                    c = c | (CNT_W'(1) << lvl);
                end
            end
            // After the full search a nonzero word has its MSB set, so a clear MSB means zero input.
            if (s == L - 1 && !w[W-1]) begin
                c = CNT_W'(W);
            end
            word_d[s] = w;
            cnt_d[s]  = c;
            tag_d[s]  = src_tag[s];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            // NOTE: data registers are cleared too so the outputs read zero straight after reset.
            for (int s = 0; s < L; s++) begin
                word_q[s] <= '0;
                cnt_q[s]  <= '0;
                tag_q[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < L; s++) begin
                if (load[s]) begin
                    valid_q[s] <= src_valid[s];
                    word_q[s]  <= word_d[s];
                    cnt_q[s]   <= cnt_d[s];
                    tag_q[s]   <= tag_d[s];
                end
            end
        end
    end

    assign io_in_ready  = load[0];
    assign io_out_valid = valid_q[L-1];
    assign io_out_count = cnt_q[L-1];
    assign io_out_norm  = word_q[L-1];
    assign io_out_tag   = tag_q[L-1];

`ifdef CLZ_ZERO_FLAG_EN
    assign io_out_zero  = cnt_q[L-1][LOG2W];
`endif

endmodule

// File: tb/tb_clz_norm_pipe.sv
// Directed and random self-checking bench for clz_norm_pipe (W=128, STAGE_LEVELS=2, TAG_W=8).
// Checks io_out_zero only when CLZ_ZERO_FLAG_EN is defined.
module tb_clz_norm_pipe;

    localparam int W     = 128;
    localparam int TAG_W = 8;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [W-1:0]     bits;
        logic [TAG_W-1:0] tag;
    } txn_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             io_in_valid = 1'b0;
    logic             io_in_ready;
    logic [W-1:0]     io_in_bits = '0;
    logic [TAG_W-1:0] io_in_tag = '0;
    logic             io_out_valid;
    logic             io_out_ready = 1'b1;
    logic [CNT_W-1:0] io_out_count;
    logic [W-1:0]     io_out_norm;
    logic [TAG_W-1:0] io_out_tag;
`ifdef CLZ_ZERO_FLAG_EN
    logic             io_out_zero;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    clz_norm_pipe #(.W(W), .STAGE_LEVELS(2), .TAG_W(TAG_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .io_in_valid (io_in_valid),
        .io_in_ready (io_in_ready),
        .io_in_bits  (io_in_bits),
        .io_in_tag   (io_in_tag),
        .io_out_valid(io_out_valid),
        .io_out_ready(io_out_ready),
        .io_out_count(io_out_count),
        .io_out_norm (io_out_norm),
        .io_out_tag  (io_out_tag)
`ifdef CLZ_ZERO_FLAG_EN
        ,
        .io_out_zero (io_out_zero)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Linear scan from the MSB: deliberately unlike the binary search in the design.
    function automatic int ref_clz(input logic [W-1:0] v);
        int n = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) return n;
            n++;
        end
        return n;
    endfunction

    // Presents one word for one cycle and waits (bounded) for its result; lat counts cycles.
    task automatic send_one(input logic [W-1:0] bits, input logic [TAG_W-1:0] tag, output int lat);
        @(negedge clock);
        io_in_valid = 1'b1;
        io_in_bits  = bits;
        io_in_tag   = tag;
        #1;
        check("send_in_ready", W'(io_in_ready), W'(1));
        lat = 0;
        do begin
            @(negedge clock);
            io_in_valid = 1'b0;
            lat++;
        end while (!io_out_valid && lat < 20);
    endtask

    initial begin
        int            lat;
        int            sent;
        int            rcv;
        int            k;
        int            n;
        bit            seen_block;
        bit            done;
        logic [W-1:0]  one_w;
        logic [W-1:0]  rnd;
        txn_t          exp_q[$];
        txn_t          e;
        bit            in_fire;
        bit            out_fire;

        one_w = W'(1);

        // Reset state
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_out_valid", W'(io_out_valid), W'(0));
        check("rst_in_ready",  W'(io_in_ready),  W'(1));
        check("rst_count",     W'(io_out_count), W'(0));
        check("rst_norm",      io_out_norm,      W'(0));
        check("rst_tag",       W'(io_out_tag),   W'(0));

        // Single bit at the LSB
        send_one(128'h1, 8'h5A, lat);
        check("t1_latency", W'(lat), W'(4));
        check("t1_count",   W'(io_out_count), W'(127));
        check("t1_norm",    io_out_norm, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
        check("t1_tag",     W'(io_out_tag), W'(8'h5A));
`ifdef CLZ_ZERO_FLAG_EN
        check("t1_zero",    W'(io_out_zero), W'(0));
`endif

        // All-zero input
        send_one(128'h0, 8'h11, lat);
        check("t2_latency", W'(lat), W'(4));
        check("t2_count",   W'(io_out_count), W'(128));
        check("t2_norm",    io_out_norm, W'(0));
        check("t2_tag",     W'(io_out_tag), W'(8'h11));
`ifdef CLZ_ZERO_FLAG_EN
        check("t2_zero",    W'(io_out_zero), W'(1));
`endif

        // MSB already set
        send_one(128'h8000_0000_0000_0000_0000_0000_0000_0000, 8'h22, lat);
        check("t3a_count", W'(io_out_count), W'(0));
        check("t3a_norm",  io_out_norm, 128'h8000_0000_0000_0000_0000_0000_0000_0000);

        // Bit 64
        send_one(128'h0000_0000_0000_0001_0000_0000_0000_0000, 8'h33, lat);
        check("t3b_count", W'(io_out_count), W'(63));
        check("t3b_norm",  io_out_norm, 128'h8000_0000_0000_0000_0000_0000_0000_0000);

        // Multi-bit pattern: highest set bit 23
        send_one(128'h0000_0000_0000_0000_0000_0000_00F0_0000, 8'h44, lat);
        check("t3c_count", W'(io_out_count), W'(104));
        check("t3c_norm",  io_out_norm, 128'hF000_0000_0000_0000_0000_0000_0000_0000);
        check("t3c_tag",   W'(io_out_tag), W'(8'h44));

        // Stream of 10 words with io_out_ready low in cycles 3..8
        @(negedge clock);
        sent = 0;
        rcv = 0;
        seen_block = 1'b0;
        for (int cyc = 0; cyc < 80 && rcv < 10; cyc++) begin
            if (cyc > 0) @(negedge clock);
            io_out_ready = !(cyc >= 3 && cyc <= 8);
            io_in_valid  = (sent < 10);
            io_in_bits   = one_w << (10 * sent);
            io_in_tag    = TAG_W'(sent);
            #1;
            if (io_in_valid && !io_in_ready && !seen_block) begin
                seen_block = 1'b1;
                check("t4_block_after", W'(sent), W'(4));
            end
            if (io_out_valid) begin
                check("t4_tag",   W'(io_out_tag),   W'(rcv));
                check("t4_count", W'(io_out_count), W'(127 - 10 * rcv));
                check("t4_norm",  io_out_norm, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
                if (io_out_ready) rcv++;
            end
            if (io_in_valid && io_in_ready) sent++;
        end
        @(negedge clock);
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        check("t4_received",   W'(rcv), W'(10));
        check("t4_sent",       W'(sent), W'(10));
        check("t4_blocked",    W'(seen_block), W'(1));
        repeat (5) @(negedge clock);
        check("t4_no_extra",   W'(io_out_valid), W'(0));

        // Fill the pipeline, then reset for one cycle
        io_out_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            io_in_valid = 1'b1;
            io_in_bits  = 128'hFF << i;
            io_in_tag   = TAG_W'(8'hA0 + i);
            #1;
            if (!io_in_ready) break;
            k++;
        end
        check("t5_fill", W'(k), W'(4));
        io_in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("t5_out_valid", W'(io_out_valid), W'(0));
        check("t5_in_ready",  W'(io_in_ready),  W'(1));
        io_out_ready = 1'b1;
        send_one(128'h0000_0000_0000_0000_0000_0001_0000_0000, 8'h77, lat);
        check("t5_latency", W'(lat), W'(4));
        check("t5_count",   W'(io_out_count), W'(95));
        check("t5_tag",     W'(io_out_tag), W'(8'h77));
        repeat (3) @(negedge clock);
        check("t5_no_stale", W'(io_out_valid), W'(0));

        // Random sweep with random valid/ready and a scoreboard
        sent = 0;
        rcv = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 60000 && !done; cyc++) begin
            @(negedge clock);
            rnd          = {$urandom(), $urandom(), $urandom(), $urandom()};
            io_in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
            io_in_bits   = rnd >> $urandom_range(128);
            io_in_tag    = TAG_W'($urandom());
            io_out_ready = ($urandom_range(3) != 0);
            #1;
            in_fire  = io_in_valid && io_in_ready;
            out_fire = io_out_valid && io_out_ready;
            if (out_fire) begin
                if (exp_q.size() == 0) begin
                    check("t6_spurious", W'(io_out_valid), W'(0));
                end else begin
                    e = exp_q.pop_front();
                    n = ref_clz(e.bits);
                    check("t6_count", W'(io_out_count), W'(n));
                    check("t6_norm",  io_out_norm, e.bits << n);
                    check("t6_tag",   W'(io_out_tag), W'(e.tag));
                    if (e.bits != '0) check("t6_norm_msb", W'(io_out_norm[W-1]), W'(1));
`ifdef CLZ_ZERO_FLAG_EN
                    check("t6_zero",  W'(io_out_zero), W'(e.bits == '0));
`endif
                    rcv++;
                end
            end
            if (in_fire) begin
                e.bits = io_in_bits;
                e.tag  = io_in_tag;
                exp_q.push_back(e);
                sent++;
            end
            done = (sent == 10000) && (exp_q.size() == 0);
        end
        io_in_valid = 1'b0;
        check("t6_received", W'(rcv), W'(10000));
        check("t6_drained",  W'(exp_q.size()), W'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
